// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - multiplexed common-anode 7-segment scanner for packed BCD.
// Optional leading-zero blanking: define BCD_SEG_SCAN_LZB_EN.
module bcd_seg_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic                  busy,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  seg_dp
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = 4 * DIGITS;

  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     cap_bcd_q, cap_bcd_d;
  logic [DIGITS-1:0] cap_dp_q, cap_dp_d;
  logic [BW-1:0]     sh_bcd_q, sh_bcd_d;
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic              pending_q, pending_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;

  logic       tick, last, boundary;
  logic [3:0] digit;
  logic [6:0] lit;
`ifdef BCD_SEG_SCAN_LZB_EN
  logic       zero_above;
`endif

  always_comb begin
    tick     = (div_q == DW'(SCAN_DIV - 1));
    last     = (idx_q == IW'(DIGITS - 1));
    boundary = tick && last;

    div_d = tick ? '0 : div_q + DW'(1);
    idx_d = idx_q;
    if (tick) idx_d = last ? '0 : idx_q + IW'(1);

    // Apply the pending value first so a same-edge load lands in capture for the next frame.
    cap_bcd_d = cap_bcd_q;
    cap_dp_d  = cap_dp_q;
    sh_bcd_d  = sh_bcd_q;
    sh_dp_d   = sh_dp_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      sh_bcd_d  = cap_bcd_q;
      sh_dp_d   = cap_dp_q;
      pending_d = 1'b0;
    end
    if (load) begin
      cap_bcd_d = bcd;
      cap_dp_d  = dp_in;
      pending_d = 1'b1;
    end

    digit = sh_bcd_q[int'(idx_q)*4 +: 4];
    case (digit)
      4'd0:    lit = 7'b0111111;
      4'd1:    lit = 7'b0000110;
      4'd2:    lit = 7'b1011011;
      4'd3:    lit = 7'b1001111;
      4'd4:    lit = 7'b1100110;
      4'd5:    lit = 7'b1101101;
      4'd6:    lit = 7'b1111101;
      4'd7:    lit = 7'b0000111;
      4'd8:    lit = 7'b1111111;
      4'd9:    lit = 7'b1101111;
      default: lit = 7'b1000000;
    endcase

    an_d     = ~(DIGITS'(1) << idx_q);
    seg_d    = ~lit;
    seg_dp_d = ~sh_dp_q[idx_q];

`ifdef BCD_SEG_SCAN_LZB_EN
    zero_above = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx_q) && sh_bcd_q[j*4 +: 4] != 4'd0) zero_above = 1'b0;
    end
    if (idx_q != '0 && !sh_dp_q[idx_q] && zero_above) begin
      an_d  = '1;
      seg_d = 7'h7F;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      idx_q     <= '0;
      cap_bcd_q <= '0;
      cap_dp_q  <= '0;
      sh_bcd_q  <= '0;
      sh_dp_q   <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      seg_dp_q  <= 1'b1;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      cap_bcd_q <= cap_bcd_d;
      cap_dp_q  <= cap_dp_d;
      sh_bcd_q  <= sh_bcd_d;
      sh_dp_q   <= sh_dp_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      seg_dp_q  <= seg_dp_d;
    end
  end

  assign busy   = pending_q;
  assign an     = an_q;
  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;

endmodule
